// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared state/access-kind types and counter width for byte_mem_ctrl
package mem_pkg;

    typedef enum logic [1:0] {INIT, IDLE, WAIT, RESP} state_e;
    typedef enum logic {RD, WR} kind_e;

    localparam int CNT_W = 4;

endpackage

// File: rtl/byte_mem_array.sv
// rtl/byte_mem_array.sv - byte-wide storage with one word read port and byte-enabled word write port
module byte_mem_array #(
    parameter int ADDR_W     = 10,
    parameter int WORD_BYTES = 4
) (
    input  logic                      clk_i,
    input  logic                      we_i,
    input  logic [ADDR_W-1:0]         waddr_i,
    input  logic [8*WORD_BYTES-1:0]   wdata_i,
    input  logic [WORD_BYTES-1:0]     wbe_i,
    input  logic [ADDR_W-1:0]         raddr_i,
    output logic [8*WORD_BYTES-1:0]   rdata_o
);

    logic [7:0] mem_q [2**ADDR_W];

    // Big-endian: byte i lives at addr+i (wrapping) and sits in the i-th most significant lane.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int i = 0; i < WORD_BYTES; i++) begin
                if (wbe_i[WORD_BYTES-1-i]) begin
                    mem_q[waddr_i + ADDR_W'(i)] <= wdata_i[8*(WORD_BYTES-1-i) +: 8];
                end
            end
        end
    end

    always_comb begin
        rdata_o = '0;
        for (int i = 0; i < WORD_BYTES; i++) begin
            rdata_o[8*(WORD_BYTES-1-i) +: 8] = mem_q[raddr_i + ADDR_W'(i)];
        end
    end

endmodule

// File: rtl/byte_mem_ctrl.sv
// rtl/byte_mem_ctrl.sv - single-outstanding byte-addressed memory controller with fixed response latency
module byte_mem_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int WORD_BYTES = 4,
    parameter int LATENCY    = 2,
    parameter int CLEAR_INIT = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      rd_req_i,
    input  logic                      wr_req_i,
    input  logic [ADDR_W-1:0]         addr_i,
    input  logic [8*WORD_BYTES-1:0]   wdata_i,
    input  logic [WORD_BYTES-1:0]     be_i,
    output logic [8*WORD_BYTES-1:0]   rdata_o,
    output logic                      rd_ready_o,
    output logic                      wr_ready_o,
    output logic                      busy_o
);

    localparam int                 DEPTH       = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0]  LAST_WORD   = ADDR_W'(DEPTH - WORD_BYTES);
    localparam logic [CNT_W-1:0]   LAT_PRELOAD = CNT_W'((LATENCY > 1) ? LATENCY - 2 : 0);

    state_e                    state_q;
    kind_e                     kind_q;
    logic                      pend_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [ADDR_W-1:0]         addr_q;
    logic [ADDR_W-1:0]         init_addr_q;
    logic [8*WORD_BYTES-1:0]   wdata_q;
    logic [WORD_BYTES-1:0]     be_q;
    logic [8*WORD_BYTES-1:0]   rdata_q;
    logic                      rd_ready_q;
    logic                      wr_ready_q;
    logic                      busy_q;

    logic                      launch;
    kind_e                     launch_kind;
    logic                      arrive;
    kind_e                     arrive_kind;
    logic                      arr_we;
    logic [ADDR_W-1:0]         arr_waddr;
    logic [8*WORD_BYTES-1:0]   arr_wdata;
    logic [WORD_BYTES-1:0]     arr_wbe;
    logic [ADDR_W-1:0]         arr_raddr;
    logic [8*WORD_BYTES-1:0]   arr_rdata;
    logic [8*WORD_BYTES-1:0]   rd_word;

    assign arr_we    = (state_q == INIT) || (state_q == RESP && kind_q == WR);
    assign arr_waddr = (state_q == INIT) ? init_addr_q : addr_q;
    assign arr_wdata = (state_q == INIT) ? '0 : wdata_q;
    assign arr_wbe   = (state_q == INIT) ? '1 : be_q;
    assign arr_raddr = (state_q == IDLE) ? addr_i : addr_q;

    byte_mem_array #(
        .ADDR_W     (ADDR_W),
        .WORD_BYTES (WORD_BYTES)
    ) u_array (
        .clk_i   (clk_i),
        .we_i    (arr_we),
        .waddr_i (arr_waddr),
        .wdata_i (arr_wdata),
        .wbe_i   (arr_wbe),
        .raddr_i (arr_raddr),
        .rdata_o (arr_rdata)
    );

    always_comb begin
        launch      = 1'b0;
        launch_kind = RD;
        if (state_q == IDLE && (rd_req_i || wr_req_i)) begin
            launch      = 1'b1;
            launch_kind = wr_req_i ? WR : RD;
        end else if (state_q == RESP && pend_q) begin
            launch      = 1'b1;
            launch_kind = RD;
        end
        arrive      = (launch && LATENCY == 1) || (state_q == WAIT && cnt_q == '0);
        arrive_kind = launch ? launch_kind : kind_q;
        // With LATENCY=1 the follow-up read samples on the same edge that commits the write.
        rd_word = arr_rdata;
        if (state_q == RESP && kind_q == WR) begin
            for (int i = 0; i < WORD_BYTES; i++) begin
                if (be_q[i]) begin
                    rd_word[8*i +: 8] = wdata_q[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= (CLEAR_INIT != 0) ? INIT : IDLE;
            kind_q      <= RD;
            pend_q      <= 1'b0;
            cnt_q       <= '0;
            addr_q      <= '0;
            init_addr_q <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            rdata_q     <= '0;
            rd_ready_q  <= 1'b0;
            wr_ready_q  <= 1'b0;
            busy_q      <= (CLEAR_INIT != 0);
        end else begin
            rd_ready_q <= arrive && arrive_kind == RD;
            wr_ready_q <= arrive && arrive_kind == WR;
            if (arrive && arrive_kind == RD) begin
                rdata_q <= rd_word;
            end
            case (state_q)
                INIT: begin
                    init_addr_q <= init_addr_q + ADDR_W'(WORD_BYTES);
                    if (init_addr_q == LAST_WORD) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                IDLE: begin
                    if (launch) begin
                        addr_q  <= addr_i;
                        wdata_q <= wdata_i;
                        be_q    <= be_i;
                        pend_q  <= rd_req_i && wr_req_i;
                        busy_q  <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    pend_q <= 1'b0;
                    if (!pend_q) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (launch) begin
                kind_q  <= launch_kind;
                cnt_q   <= LAT_PRELOAD;
                state_q <= (LATENCY == 1) ? RESP : WAIT;
            end
        end
    end

    assign rdata_o    = rdata_q;
    assign rd_ready_o = rd_ready_q;
    assign wr_ready_o = wr_ready_q;
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_byte_mem_ctrl.sv
// tb/tb_byte_mem_ctrl.sv - randomized self-checking bench for byte_mem_ctrl against a byte-array model
module tb_byte_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst      [2];
    logic        rd_req   [2];
    logic        wr_req   [2];
    logic [9:0]  addr     [2];
    logic [31:0] wdata    [2];
    logic [3:0]  be       [2];
    logic [31:0] rdata    [2];
    logic        rd_ready [2];
    logic        wr_ready [2];
    logic        busy     [2];

    int          vectors = 0;
    int          errors  = 0;
    logic [31:0] last_rd [2];
    logic [7:0]  ref_mem [2][1024];
    logic [9:0]  known1  [$];

    always #5 clk = ~clk;

    byte_mem_ctrl #(.ADDR_W(10), .WORD_BYTES(4), .LATENCY(2), .CLEAR_INIT(1)) dut (
        .clk_i(clk), .rst_i(rst[0]), .rd_req_i(rd_req[0]), .wr_req_i(wr_req[0]),
        .addr_i(addr[0]), .wdata_i(wdata[0]), .be_i(be[0]), .rdata_o(rdata[0]),
        .rd_ready_o(rd_ready[0]), .wr_ready_o(wr_ready[0]), .busy_o(busy[0])
    );

    byte_mem_ctrl #(.ADDR_W(10), .WORD_BYTES(4), .LATENCY(1), .CLEAR_INIT(0)) dut1 (
        .clk_i(clk), .rst_i(rst[1]), .rd_req_i(rd_req[1]), .wr_req_i(wr_req[1]),
        .addr_i(addr[1]), .wdata_i(wdata[1]), .be_i(be[1]), .rdata_o(rdata[1]),
        .rd_ready_o(rd_ready[1]), .wr_ready_o(wr_ready[1]), .busy_o(busy[1])
    );

    function automatic logic [31:0] mread(input int w, input logic [9:0] a);
        logic [31:0] r;
        logic [9:0]  ai;
        for (int i = 0; i < 4; i++) begin
            ai = a + 10'(i);
            r[31-8*i -: 8] = ref_mem[w][ai];
        end
        return r;
    endfunction

    task automatic mwrite(input int w, input logic [9:0] a, input logic [31:0] d, input logic [3:0] b);
        logic [9:0] ai;
        for (int i = 0; i < 4; i++) begin
            ai = a + 10'(i);
            if (b[3-i]) ref_mem[w][ai] = d[31-8*i -: 8];
        end
    endtask

    task automatic mclear(input int w);
        for (int i = 0; i < 1024; i++) ref_mem[w][i] = 8'h00;
    endtask

    task automatic wait_idle(input int w);
        int n;
        n = 0;
        while (busy[w] !== 1'b0 && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        vectors++;
        if (busy[w] !== 1'b0) begin
            errors++;
            $display("FAIL idle_timeout dut%0d busy=%b required 0", w, busy[w]);
        end
    endtask

    // Drives one request, then watches a fixed window and checks pulse timing, data and holding.
    task automatic access(input int w, input bit do_rd, input bit do_wr,
                          input logic [9:0] a, input logic [31:0] d, input logic [3:0] b);
        int          lat, wr_k, rd_k;
        bit          both;
        logic [31:0] exp, got;
        lat  = (w == 0) ? 2 : 1;
        wait_idle(w);
        @(negedge clk);
        addr[w] = a; wdata[w] = d; be[w] = b; rd_req[w] = do_rd; wr_req[w] = do_wr;
        @(posedge clk); #1;
        rd_req[w] = 1'b0; wr_req[w] = 1'b0;
        addr[w] = 10'($urandom); wdata[w] = $urandom; be[w] = 4'($urandom);
        if (do_wr) mwrite(w, a, d, b);
        exp  = mread(w, a);
        wr_k = 0; rd_k = 0; both = 1'b0; got = '0;
        for (int k = 1; k <= 4 * lat + 4; k++) begin
            if (k > 1) begin @(posedge clk); #1; end
            if (wr_ready[w] === 1'b1 && rd_ready[w] === 1'b1) both = 1'b1;
            if (wr_ready[w] === 1'b1 && wr_k == 0) wr_k = k;
            if (rd_ready[w] === 1'b1 && rd_k == 0) begin rd_k = k; got = rdata[w]; end
        end
        vectors++;
        if (both) begin
            errors++;
            $display("FAIL ready_overlap dut%0d addr=%h both pulses high, required never", w, a);
        end
        if (do_wr) begin
            vectors++;
            if (wr_k != lat) begin
                errors++;
                $display("FAIL wr_latency dut%0d addr=%h got %0d required %0d", w, a, wr_k, lat);
            end
        end
        if (do_rd) begin
            vectors += 2;
            if (rd_k != (do_wr ? 2 * lat : lat)) begin
                errors++;
                $display("FAIL rd_latency dut%0d addr=%h got %0d required %0d", w, a, rd_k, do_wr ? 2 * lat : lat);
            end
            if (got !== exp) begin
                errors++;
                $display("FAIL rdata dut%0d addr=%h got %h required %h", w, a, got, exp);
            end
            last_rd[w] = exp;
        end
        vectors++;
        if (rdata[w] !== last_rd[w]) begin
            errors++;
            $display("FAIL rdata_hold dut%0d got %h required %h", w, rdata[w], last_rd[w]);
        end
    endtask

    task automatic test_reset();
        int cnt;
        rst[0] = 1'b1; rst[1] = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors += 5;
        if (busy[0] !== 1'b1) begin errors++; $display("FAIL reset_busy0 got %b required 1", busy[0]); end
        if (busy[1] !== 1'b0) begin errors++; $display("FAIL reset_busy1 got %b required 0", busy[1]); end
        if (rdata[0] !== 32'h0 || rdata[1] !== 32'h0) begin
            errors++; $display("FAIL reset_rdata got %h/%h required 0", rdata[0], rdata[1]);
        end
        if (rd_ready[0] !== 1'b0 || rd_ready[1] !== 1'b0) begin
            errors++; $display("FAIL reset_rd_ready got %b/%b required 0", rd_ready[0], rd_ready[1]);
        end
        if (wr_ready[0] !== 1'b0 || wr_ready[1] !== 1'b0) begin
            errors++; $display("FAIL reset_wr_ready got %b/%b required 0", wr_ready[0], wr_ready[1]);
        end
        rst[0] = 1'b0; rst[1] = 1'b0;
        cnt = 1;
        for (int n = 0; n < 400; n++) begin
            @(posedge clk); #1;
            if (busy[0] !== 1'b1) break;
            cnt++;
        end
        vectors++;
        if (cnt != 256) begin errors++; $display("FAIL init_cycles got %0d required 256", cnt); end
        mclear(0);
        last_rd[0] = '0; last_rd[1] = '0;
    endtask

    task automatic test_clear();
        access(0, 1'b1, 1'b0, 10'h3FC, 32'h0, 4'h0);
    endtask

    task automatic test_directed();
        access(0, 1'b0, 1'b1, 10'h010, 32'hDEADBEEF, 4'hF);
        access(0, 1'b1, 1'b0, 10'h010, 32'h0, 4'h0);
        access(0, 1'b0, 1'b1, 10'h010, 32'h11223344, 4'b0101);
        access(0, 1'b1, 1'b0, 10'h010, 32'h0, 4'h0);
        vectors++;
        if (rdata[0] !== 32'hDE22BE44) begin
            errors++; $display("FAIL partial_be got %h required DE22BE44", rdata[0]);
        end
    endtask

    task automatic test_wrap();
        access(0, 1'b0, 1'b1, 10'h3FE, 32'hA1B2C3D4, 4'hF);
        access(0, 1'b1, 1'b0, 10'h000, 32'h0, 4'h0);
        vectors++;
        if (rdata[0] !== 32'hC3D40000) begin
            errors++; $display("FAIL wrap got %h required C3D40000", rdata[0]);
        end
        access(0, 1'b1, 1'b0, 10'h3FE, 32'h0, 4'h0);
    endtask

    task automatic test_dual();
        access(0, 1'b1, 1'b1, 10'h020, 32'hCAFEF00D, 4'hF);
        vectors++;
        if (rdata[0] !== 32'hCAFEF00D) begin
            errors++; $display("FAIL dual_rdata got %h required CAFEF00D", rdata[0]);
        end
        access(0, 1'b0, 1'b1, 10'h022, 32'h0000FFFF, 4'h0);
        access(0, 1'b1, 1'b0, 10'h020, 32'h0, 4'h0);
        access(1, 1'b1, 1'b1, 10'h3FD, 32'h5A6B7C8D, 4'hF);
        known1.push_back(10'h3FD);
    endtask

    task automatic test_random();
        logic [9:0] a;
        int         op;
        for (int n = 0; n < 60; n++) begin
            a  = ($urandom_range(0, 3) == 0) ? 10'(10'h3FC + 10'($urandom_range(0, 3))) : 10'($urandom);
            op = $urandom_range(0, 2);
            access(0, op != 1, op != 0, a, $urandom, 4'($urandom));
        end
        for (int n = 0; n < 25; n++) begin
            op = $urandom_range(0, 2);
            if (op == 0) begin
                a = known1[$urandom_range(0, known1.size() - 1)];
            end else begin
                a = 10'($urandom);
                known1.push_back(a);
            end
            access(1, op != 1, op != 0, a, $urandom, 4'hF);
        end
    endtask

    task automatic test_reset_abort();
        // LATENCY=2 controller: reset lands in the WAIT cycle of a write.
        wait_idle(0);
        @(negedge clk);
        addr[0] = 10'h040; wdata[0] = 32'h99887766; be[0] = 4'hF; wr_req[0] = 1'b1;
        @(posedge clk); #1;
        wr_req[0] = 1'b0;
        rst[0] = 1'b1;
        #1;
        vectors += 3;
        if (wr_ready[0] !== 1'b0) begin errors++; $display("FAIL abort_wr_ready0 got %b required 0", wr_ready[0]); end
        if (busy[0] !== 1'b1) begin errors++; $display("FAIL abort_busy0 got %b required 1", busy[0]); end
        if (rdata[0] !== 32'h0) begin errors++; $display("FAIL abort_rdata0 got %h required 0", rdata[0]); end
        @(negedge clk);
        rst[0] = 1'b0;
        mclear(0);
        last_rd[0] = '0;
        access(0, 1'b1, 1'b0, 10'h040, 32'h0, 4'h0);

        // LATENCY=1, no clear: pre-existing contents must survive an aborted write.
        access(1, 1'b0, 1'b1, 10'h040, 32'h12345678, 4'hF);
        access(1, 1'b1, 1'b0, 10'h040, 32'h0, 4'h0);
        @(negedge clk);
        addr[1] = 10'h040; wdata[1] = 32'hFFFFFFFF; be[1] = 4'hF; wr_req[1] = 1'b1;
        @(posedge clk); #1;
        wr_req[1] = 1'b0;
        rst[1] = 1'b1;
        #1;
        vectors += 3;
        if (wr_ready[1] !== 1'b0) begin errors++; $display("FAIL abort_wr_ready1 got %b required 0", wr_ready[1]); end
        if (busy[1] !== 1'b0) begin errors++; $display("FAIL abort_busy1 got %b required 0", busy[1]); end
        if (rdata[1] !== 32'h0) begin errors++; $display("FAIL abort_rdata1 got %h required 0", rdata[1]); end
        @(negedge clk);
        rst[1] = 1'b0;
        last_rd[1] = '0;
        access(1, 1'b1, 1'b0, 10'h040, 32'h0, 4'h0);
    endtask

    initial begin
        for (int w = 0; w < 2; w++) begin
            rst[w] = 1'b0; rd_req[w] = 1'b0; wr_req[w] = 1'b0;
            addr[w] = '0; wdata[w] = '0; be[w] = '0; last_rd[w] = '0;
        end
        test_reset();
        test_clear();
        test_directed();
        test_wrap();
        test_dual();
        test_random();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
